// File: rtl/muli_iter_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding and counter sizing.
package muli_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Step counter width for a given operand width (never narrower than 1 bit).
    function automatic int cnt_width(input int data_type);
        return (data_type <= 2) ? 1 : $clog2(data_type);
    endfunction

endpackage

// File: rtl/join_type.sv
// N-way valid/ready join: the output fires only when every input is valid, and each
// input is told ready only when the consumer is ready and all the other inputs are valid.
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    output logic [SIZE-1:0] ins_ready,
    output logic            outs_valid,
    input  logic            outs_ready
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ins_ready  = '0;
        outs_valid = &ins_valid;
        for (int i = 0; i < SIZE; i++) begin
            ins_ready[i] = outs_ready;
            for (int j = 0; j < SIZE; j++) begin
                if (j != i) begin
                    ins_ready[i] = ins_ready[i] & ins_valid[j];
                end
            end
        end
    end

endmodule

// File: rtl/muli_iter.sv
// Iterative shift-add multiplier: result = (lhs*rhs) mod 2^DATA_TYPE after a fixed
// DATA_TYPE-cycle latency, with joined lhs/rhs input channels and one result channel.
module muli_iter
    import muli_iter_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    input  logic                 result_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    output logic                 lhs_ready,
    output logic                 rhs_ready
);

    localparam int            CW   = cnt_width(DATA_TYPE);
    localparam logic [CW-1:0] LAST = CW'(DATA_TYPE - 1);

    state_t               state, state_next;
    logic [DATA_TYPE-1:0] a, b, acc, acc_next;
    logic [CW-1:0]        cnt;
    logic                 can_accept, join_valid, accept, last_step;
    logic [1:0]           ins_ready;

    assign can_accept = (state == IDLE) | ((state == DONE) & result_ready);
    assign accept     = join_valid & can_accept;
    assign last_step  = (state == BUSY) && (cnt == LAST);
    assign acc_next   = b[0] ? acc + a : acc;

    join_type #(.SIZE(2)) u_join (
        .ins_valid  ({rhs_valid, lhs_valid}),
        .ins_ready  (ins_ready),
        .outs_valid (join_valid),
        .outs_ready (can_accept)
    );

    assign {rhs_ready, lhs_ready} = ins_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)       state_next = BUSY;
            BUSY:    if (last_step)    state_next = DONE;
            DONE:    if (result_ready) state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fixed latency: all DATA_TYPE steps always run, even once b has shifted to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: datapath registers are individual flops, not memory, so they all reset cleanly.
            a   <= '0;
            b   <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            a   <= lhs;
            b   <= rhs;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            acc <= acc_next;
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= last_step ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (last_step) begin
            result       <= acc_next;
            result_valid <= 1'b1;
        end else if ((state == DONE) && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muli_iter.sv
// Directed bench for muli_iter (DATA_TYPE=32): vector table plus backpressure,
// join, back-to-back and mid-operation reset sequences.
module tb_muli_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] lhs, rhs, result;
    logic         lhs_valid, rhs_valid, result_ready;
    logic         result_valid, lhs_ready, rhs_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] lhs;
        logic [W-1:0] rhs;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    muli_iter #(.DATA_TYPE(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .lhs          (lhs),
        .lhs_valid    (lhs_valid),
        .rhs          (rhs),
        .rhs_valid    (rhs_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_valid (result_valid),
        .lhs_ready    (lhs_ready),
        .rhs_ready    (rhs_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents both operands, confirms the join is ready, and lets the accept edge happen.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        lhs       = x;
        rhs       = y;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        #1;
        check("ready_before_accept", {lhs_ready, rhs_ready}, 2'b11);
        step();
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        #1;
        check("busy_ready_low", {lhs_ready, rhs_ready}, 2'b00);
    endtask

    // Counts edges from the accept edge until result_valid, bounded at 40.
    task automatic wait_result(input string name, input logic [W-1:0] exp);
        int lat = 0;
        while (!result_valid && lat < 40) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, W);
        check({name, "_value"}, result, exp);
    endtask

    initial begin
        vecs[0] = '{32'd7,        32'd6,        32'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[3] = '{32'd0,        32'h1234,     32'h00000000};
        vecs[4] = '{32'h12345678, 32'd9,        32'hA3D70A38};
        vecs[5] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE};
        vecs[6] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[7] = '{32'd1,        32'hDEADBEEF, 32'hDEADBEEF};

        rst          = 1'b0;
        lhs          = '0;
        rhs          = '0;
        lhs_valid    = 1'b0;
        rhs_valid    = 1'b0;
        result_ready = 1'b1;
        #12;
        check("reset_result_valid", result_valid, 1'b0);
        check("reset_result", result, 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].lhs, vecs[i].rhs);
            wait_result($sformatf("vec%0d", i), vecs[i].exp);
            step();
            check($sformatf("vec%0d_valid_one_cycle", i), result_valid, 1'b0);
            check($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
        end

        // Join: only lhs valid must never accept.
        lhs       = 32'd11;
        rhs       = 32'd13;
        lhs_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("join_lhs_ready", lhs_ready, 1'b0);
            check("join_rhs_ready", rhs_ready, 1'b1);
        end
        rhs_valid = 1'b1;
        #1;
        check("join_ready_both", {lhs_ready, rhs_ready}, 2'b11);
        step();
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        wait_result("join", 32'd143);
        step();

        // Backpressure with the next pair already waiting, then back-to-back accept.
        result_ready = 1'b0;
        start_op(32'h12345678, 32'h10);
        wait_result("bp", 32'h23456780);
        lhs       = 32'd3;
        rhs       = 32'd7;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid_held", result_valid, 1'b1);
            check("bp_result_held", result, 32'h23456780);
            check("bp_ready_low", {lhs_ready, rhs_ready}, 2'b00);
        end
        result_ready = 1'b1;
        #1;
        check("b2b_ready_on_done", {lhs_ready, rhs_ready}, 2'b11);
        step();
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        check("b2b_handshake_done", result_valid, 1'b0);
        #1;
        check("b2b_busy_ready_low", {lhs_ready, rhs_ready}, 2'b00);
        wait_result("b2b", 32'd21);
        step();

        // Asynchronous reset in the middle of a multiply.
        start_op(32'd9, 32'd9);
        repeat (10) step();
        rst = 1'b0;
        #1;
        check("midrst_result_valid", result_valid, 1'b0);
        check("midrst_result", result, 32'd0);
        step();
        rst = 1'b1;
        step();
        check("midrst_idle_valid", result_valid, 1'b0);
        start_op(32'd3, 32'd5);
        wait_result("after_rst", 32'd15);
        step();
        check("after_rst_valid_low", result_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
